spy_delay_sampler: RTL and testbench

//  Parametrised measurement controller for a chained spy delay path: launches an edge into an external

---
 rtl/spy_delay_sampler.sv | 144 ++++++++++++++
 tb/tb_spy_delay_sampler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spy_delay_sampler.sv
// Spy delay path sampler: launches an edge into an external inverting chain,
// snapshots the taps one clock later and accumulates sum/min/max of the edge depth.
module spy_delay_sampler #(
   parameter int NUM_TAPS      = 32,
   parameter int NUM_SAMPLES   = 16,
   parameter int SETTLE_CYCLES = 8,
   localparam int DW = $clog2(NUM_TAPS + 1),
   localparam int SW = DW + $clog2(NUM_SAMPLES)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   output logic                launch,
   input  logic [NUM_TAPS-1:0] taps,
   output logic                busy,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [SW-1:0]       res_sum,
   output logic [DW-1:0]       res_min,
   output logic [DW-1:0]       res_max,
   output logic                res_bubble
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] SETTLE = 3'd1;
   localparam logic [2:0] BASE   = 3'd2;
   localparam logic [2:0] LAUNCH = 3'd3;
   localparam logic [2:0] CAPT   = 3'd4;
   localparam logic [2:0] DECODE = 3'd5;
   localparam logic [2:0] DONE   = 3'd6;

   localparam int CW = $clog2(SETTLE_CYCLES);
   localparam int NW = $clog2(NUM_SAMPLES + 1);
   localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [NW-1:0] CNT_LAST = NW'(NUM_SAMPLES - 1);

   logic [2:0]          state;
   logic [CW-1:0]       set_cnt;
   logic [NW-1:0]       cnt;
   logic [NUM_TAPS-1:0] base_q;
   logic [NUM_TAPS-1:0] cap_q;
   logic [SW-1:0]       sum_q;
   logic [DW-1:0]       min_q;
   logic [DW-1:0]       max_q;
   logic                bub_q;

   logic [NUM_TAPS-1:0] diff;
   logic [DW-1:0]       depth;
   logic                hit0;
   logic                bub;

   // Thermometer decode of the XORed snapshot; anything above the first 0 is a bubble
   always_comb begin
      diff  = base_q ^ cap_q;
      depth = '0;
      hit0  = 1'b0;
      bub   = 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
         if (!diff[i]) hit0 = 1'b1;
         else if (hit0) bub = 1'b1;
         else depth = depth + DW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         set_cnt    <= '0;
         cnt        <= '0;
         base_q     <= '0;
         cap_q      <= '0;
         sum_q      <= '0;
         min_q      <= '1;
         max_q      <= '0;
         bub_q      <= 1'b0;
         launch     <= 1'b0;
         busy       <= 1'b0;
         res_valid  <= 1'b0;
         res_sum    <= '0;
         res_min    <= '0;
         res_max    <= '0;
         res_bubble <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state   <= SETTLE;
                  set_cnt <= '0;
                  cnt     <= '0;
                  sum_q   <= '0;
                  min_q   <= '1;
                  max_q   <= '0;
                  bub_q   <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            SETTLE: begin
               if (set_cnt == SET_LAST) begin
                  state   <= BASE;
                  set_cnt <= '0;
               end else begin
                  set_cnt <= set_cnt + CW'(1);
               end
            end
            BASE: begin
               base_q <= taps;
               state  <= LAUNCH;
            end
            LAUNCH: begin
               launch <= ~launch;
               state  <= CAPT;
            end
            // Unsynchronised on purpose: this flop's sample is the measurement
            CAPT: begin
               cap_q <= taps;
               state <= DECODE;
            end
            DECODE: begin
               sum_q <= sum_q + SW'(depth);
               if (depth < min_q) min_q <= depth;
               if (depth > max_q) max_q <= depth;
               if (bub) bub_q <= 1'b1;
               cnt   <= cnt + NW'(1);
               state <= (cnt == CNT_LAST) ? DONE : SETTLE;
            end
            DONE: begin
               if (!res_valid) begin
                  res_valid  <= 1'b1;
                  res_sum    <= sum_q;
                  res_min    <= min_q;
                  res_max    <= max_q;
                  res_bubble <= bub_q;
               end else if (res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spy_delay_sampler.sv
// Scoreboard bench for spy_delay_sampler: models the chain by flipping taps
// after each launch edge and checks the accumulated results and timing.
module tb_spy_delay_sampler;

   localparam int NT = 32;
   localparam int NS = 4;
   localparam int SC = 8;
   localparam int DW = $clog2(NT + 1);
   localparam int SW = DW + $clog2(NS);
   localparam int LAT = NS * (SC + 4) + 1;

   typedef struct packed {
      logic [SW-1:0] sum;
      logic [DW-1:0] mn;
      logic [DW-1:0] mx;
      logic          bub;
   } res_t;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          launch;
   logic [NT-1:0] taps;
   logic          busy;
   logic          res_valid;
   logic          res_ready;
   logic [SW-1:0] res_sum;
   logic [DW-1:0] res_min;
   logic [DW-1:0] res_max;
   logic          res_bubble;

   int checks = 0;
   int errors = 0;

   res_t          exp_q[$];
   logic [NT-1:0] diff_q[$];

   spy_delay_sampler #(
      .NUM_TAPS(NT), .NUM_SAMPLES(NS), .SETTLE_CYCLES(SC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .launch(launch),
      .taps(taps), .busy(busy), .res_valid(res_valid),
      .res_ready(res_ready), .res_sum(res_sum), .res_min(res_min),
      .res_max(res_max), .res_bubble(res_bubble)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic queue_meas(input logic [NT-1:0] d0, input logic [NT-1:0] d1,
                             input logic [NT-1:0] d2, input logic [NT-1:0] d3);
      logic [NT-1:0] ds[4];
      res_t e;
      int s, mn, mx;
      bit b;
      ds[0] = d0; ds[1] = d1; ds[2] = d2; ds[3] = d3;
      s = 0; mn = NT + 100; mx = -1; b = 0;
      for (int k = 0; k < 4; k++) begin
         int i;
         i = 0;
         while (i < NT && ds[k][i]) i++;
         s += i;
         if (i < mn) mn = i;
         if (i > mx) mx = i;
         if (i < NT && (ds[k] >> i) != 0) b = 1;
         diff_q.push_back(ds[k]);
      end
      e.sum = SW'(s);
      e.mn  = DW'(mn);
      e.mx  = DW'(mx);
      e.bub = b;
      exp_q.push_back(e);
   endtask

   task automatic do_measure(input int hold, input string name);
      res_t e;
      int cyc, tog;
      logic pl;
      cyc = 0;
      tog = 0;
      @(negedge clk);
      start = 1'b1;
      pl = launch;
      while (1) begin
         @(posedge clk);
         cyc++;
         #1;
         start = 1'b0;
         if (launch !== pl) begin
            tog++;
            pl = launch;
            if (diff_q.size() > 0) taps = taps ^ diff_q.pop_front();
         end
         if (res_valid === 1'b1 || cyc > 2000) break;
      end
      e = exp_q.pop_front();
      checks++;
      if (res_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s timeout: res_valid=%b after %0d cycles, required 1", name, res_valid, cyc);
      end
      checks++;
      if (cyc - 1 != LAT) begin
         errors++;
         $display("FAIL %s latency: got %0d, required %0d", name, cyc - 1, LAT);
      end
      checks++;
      if (tog != NS) begin
         errors++;
         $display("FAIL %s launch toggles: got %0d, required %0d", name, tog, NS);
      end
      checks++;
      if ({res_sum, res_min, res_max, res_bubble} !== e) begin
         errors++;
         $display("FAIL %s result: sum=%0d min=%0d max=%0d bub=%b, required sum=%0d min=%0d max=%0d bub=%b",
                  name, res_sum, res_min, res_max, res_bubble, e.sum, e.mn, e.mx, e.bub);
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         start = (h % 5 == 0);
         @(posedge clk);
         #1;
         checks++;
         if ({res_sum, res_min, res_max, res_bubble} !== e || res_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s hold %0d: valid=%b busy=%b sum=%0d, required valid=1 busy=1 sum=%0d",
                     name, h, res_valid, busy, res_sum, e.sum);
         end
      end
      @(negedge clk);
      res_ready = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s handshake: valid=%b busy=%b, required 0 0", name, res_valid, busy);
      end
      @(negedge clk);
      start = 1'b0;
      res_ready = 1'b0;
      pl = launch;
      repeat (SC + 6) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || launch !== pl || res_sum !== e.sum) begin
         errors++;
         $display("FAIL %s idle after: busy=%b launch=%b sum=%0d, required busy=0 launch=%b sum=%0d",
                  name, busy, launch, res_sum, pl, e.sum);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      res_ready = 1'b0;
      taps = 32'h5A3C_96E1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({launch, busy, res_valid, res_sum, res_min, res_max, res_bubble} !== '0) begin
         errors++;
         $display("FAIL reset: launch=%b busy=%b valid=%b sum=%0d min=%0d max=%0d bub=%b, required all 0",
                  launch, busy, res_valid, res_sum, res_min, res_max, res_bubble);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_uniform();
      queue_meas(32'hFF, 32'hFF, 32'hFF, 32'hFF);
      do_measure(0, "uniform8");
   endtask

   task automatic test_depth_seq();
      queue_meas(32'h0, 32'h1F, 32'hFFFF_FFFF, 32'hFFF);
      do_measure(0, "depthseq");
   endtask

   task automatic test_bubble();
      queue_meas(32'hFF, 32'h0F0F, 32'hFF, 32'hFF);
      do_measure(0, "bubble");
   endtask

   task automatic test_backpressure();
      queue_meas(32'h7, 32'h3FFF, 32'h1, 32'h7FFF_FFFF);
      do_measure(20, "backpressure");
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         logic [NT-1:0] d[4];
         for (int k = 0; k < 4; k++) begin
            logic [NT:0] t;
            t = (33'd1 << $urandom_range(0, NT)) - 33'd1;
            d[k] = t[NT-1:0];
         end
         queue_meas(d[0], d[1], d[2], d[3]);
         do_measure(r, "random");
      end
   endtask

   task automatic test_reset_midcapt();
      logic pl;
      int n;
      n = 0;
      @(negedge clk);
      start = 1'b1;
      pl = launch;
      while (launch === pl && n < 200) begin
         @(posedge clk);
         n++;
         #1;
         start = 1'b0;
      end
      checks++;
      if (launch === pl) begin
         errors++;
         $display("FAIL midcapt: launch never toggled within %0d cycles", n);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({launch, busy, res_valid, res_sum, res_min, res_max, res_bubble} !== '0) begin
         errors++;
         $display("FAIL midcapt reset: launch=%b busy=%b valid=%b sum=%0d min=%0d max=%0d, required all 0",
                  launch, busy, res_valid, res_sum, res_min, res_max);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (SC + 6) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || launch !== 1'b0) begin
         errors++;
         $display("FAIL midcapt idle: busy=%b launch=%b, required 0 0", busy, launch);
      end
      queue_meas(32'h3F, 32'h3F, 32'hFFFF, 32'h1);
      do_measure(0, "after_reset");
   endtask

   initial begin
      test_reset();
      test_uniform();
      test_depth_seq();
      test_bubble();
      test_backpressure();
      test_random();
      test_reset_midcapt();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
